// File: rtl/one_rv_pkg.sv
// Shared sizing helpers for the valid/ready wrapper around the fixed-latency adder.
package one_rv_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_LATENCY = 2;
    localparam int DEF_DEPTH   = 4;

    // Width able to hold 0..depth inclusive (credits, FIFO occupancy).
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/one_rv_fifo.sv
// Synchronous result FIFO; no fall-through, empty head reads as zero.
module one_rv_fifo
    import one_rv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [cnt_w(DEPTH)-1:0]    count,
    output logic                       empty,
    output logic                       full
);

    localparam int CW = cnt_w(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= bump(wr_ptr);
            if (rd_en) rd_ptr <= bump(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign rd_data = empty ? '0 : mem[rd_ptr];

    a_no_ovf: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_en && full));
    a_no_unf: assert property (@(posedge clk) disable iff (!rst_n)
        !(rd_en && empty));

endmodule

// File: rtl/one_rv_wrapper.sv
// Credit-based valid/ready front end and result FIFO around a free-running,
// stall-free adder pipeline.
module one_rv_wrapper
    import one_rv_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int LATENCY    = DEF_LATENCY,
    parameter int FIFO_DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum
);

    localparam int CW = cnt_w(FIFO_DEPTH);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] sum;
    } stage_t;

    logic [CW-1:0]          credit;
    logic [CW-1:0]          count;
    logic                   in_fire;
    logic                   out_fire;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   v0;
    logic [WIDTH-1:0]       x0;
    logic [WIDTH-1:0]       y0;
    stage_t [LATENCY-1:0]   st;
    int                     inflight;

    // in_ready comes only from the credit register, never from out_ready.
    assign in_ready  = (credit != '0);
    assign in_fire   = in_valid & in_ready;
    assign out_valid = ~fifo_empty;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit <= CW'(FIFO_DEPTH);
        end else begin
            case ({in_fire, out_fire})
                2'b10:   credit <= credit - 1'b1;
                2'b01:   credit <= credit + 1'b1;
                default: credit <= credit;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) v0 <= 1'b0;
        else        v0 <= in_fire;
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            x0 <= in_x;
            y0 <= in_y;
        end
    end

    assign st[0] = '{valid: v0, sum: x0 + y0};

    for (genvar k = 1; k < LATENCY; k++) begin : g_stage
        logic             v;
        logic [WIDTH-1:0] s;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) v <= 1'b0;
            else        v <= st[k-1].valid;
        end

        always_ff @(posedge clk) begin
            s <= st[k-1].sum;
        end

        assign st[k] = '{valid: v, sum: s};
    end

    one_rv_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (st[LATENCY-1].valid),
        .wr_data (st[LATENCY-1].sum),
        .rd_en   (out_fire),
        .rd_data (out_sum),
        .count   (count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    always_comb begin
        inflight = 0;
        for (int k = 0; k < LATENCY; k++) begin
            inflight += int'(st[k].valid);
        end
    end

    a_credit_sum: assert property (@(posedge clk) disable iff (!rst_n)
        int'(credit) + int'(count) + inflight == FIFO_DEPTH);
    a_full_no_credit: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_full && credit != '0));

endmodule

// File: tb/tb_one_rv_wrapper.sv
// Directed self-checking bench for one_rv_wrapper (default and 8/1/2 configs).
module tb_one_rv_wrapper;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x;
    logic [31:0] in_y;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;

    logic        b_in_valid;
    logic        b_in_ready;
    logic [7:0]  b_in_x;
    logic [7:0]  b_in_y;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [7:0]  b_out_sum;

    int          checks = 0;
    int          errors = 0;
    int          sent;
    int          rcvd;
    logic        acc;
    logic        rx;
    logic [31:0] head;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    one_rv_wrapper u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
    );

    one_rv_wrapper #(
        .WIDTH      (8),
        .LATENCY    (1),
        .FIFO_DEPTH (2)
    ) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_x      (b_in_x),
        .in_y      (b_in_y),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_sum   (b_out_sum)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        out_ready = 1'b1;
        for (int n = 0; n < budget && exp_q.size() > 0; n++) begin
            rx   = out_valid;
            head = out_sum;
            tick();
            if (rx) check("drain_sum", head, exp_q.pop_front());
        end
        out_ready = 1'b0;
        check("drain_left", 32'(exp_q.size()), 32'd0);
        check("drain_empty", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_x        = '0;
        in_y        = '0;
        out_ready   = 1'b0;
        b_in_valid  = 1'b0;
        b_in_x      = '0;
        b_in_y      = '0;
        b_out_ready = 1'b0;
        repeat (2) tick();

        check("rst_ovalid", 32'(out_valid), 32'd0);
        check("rst_iready", 32'(in_ready), 32'd1);
        check("rst_sum", out_sum, 32'd0);
        check("rst_b_iready", 32'(b_in_ready), 32'd1);
        check("rst_b_ovalid", 32'(b_out_valid), 32'd0);
        rst_n = 1'b1;

        // single op, accepted at edge 0
        in_valid = 1'b1;
        in_x     = 32'd3;
        in_y     = 32'd5;
        tick();
        in_valid = 1'b0;
        check("one_e0_ovalid", 32'(out_valid), 32'd0);
        check("one_e0_iready", 32'(in_ready), 32'd1);
        tick();
        check("one_e1_ovalid", 32'(out_valid), 32'd0);
        check("one_e1_iready", 32'(in_ready), 32'd1);
        tick();
        check("one_e2_ovalid", 32'(out_valid), 32'd1);
        check("one_e2_sum", out_sum, 32'd8);
        check("one_e2_iready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("one_popped", 32'(out_valid), 32'd0);

        // streaming 8 ops with out_ready held high
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            in_valid = (k < 8);
            in_x     = 32'(k);
            in_y     = 32'd100;
            check("strm_iready", 32'(in_ready), 32'd1);
            tick();
            check("strm_ovalid", 32'(out_valid), 32'(k >= 2 && k <= 9));
            if (k >= 2 && k <= 9) check("strm_sum", out_sum, 32'(100 + k - 2));
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // back-pressure: 8 stalled cycles, then resume
        sent = 0;
        rcvd = 0;
        for (int cyc = 0; cyc < 60 && rcvd < 6; cyc++) begin
            out_ready = (cyc >= 8);
            if (cyc == 8) begin
                check("bp_accepts", 32'(sent), 32'd4);
                check("bp_iready", 32'(in_ready), 32'd0);
            end
            in_valid = (sent < 6);
            in_x     = 32'(10 + sent);
            in_y     = 32'd1;
            acc  = in_valid && in_ready;
            rx   = out_valid && out_ready;
            head = out_sum;
            if (out_valid && !out_ready) check("bp_hold", out_sum, 32'd11);
            tick();
            if (acc) sent++;
            if (rx) begin
                check("bp_order", head, 32'(11 + rcvd));
                rcvd++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("bp_rcvd", 32'(rcvd), 32'd6);
        tick();
        check("bp_no_dup", 32'(out_valid), 32'd0);

        // full FIFO with zero credit, then pop / simultaneous fire
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_x     = 32'(20 + i);
            in_y     = 32'd0;
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();
        check("full_iready", 32'(in_ready), 32'd0);
        check("full_head", out_sum, 32'd20);
        out_ready = 1'b1;
        check("pop_c_iready", 32'(in_ready), 32'd0);
        tick();
        check("pop_c1_iready", 32'(in_ready), 32'd1);
        check("pop_c1_head", out_sum, 32'd21);
        in_valid = 1'b1;
        in_x     = 32'd30;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("both_iready", 32'(in_ready), 32'd1);
        check("both_head", out_sum, 32'd22);
        in_valid = 1'b1;
        in_x     = 32'd31;
        tick();
        in_valid = 1'b0;
        check("inonly_iready", 32'(in_ready), 32'd0);
        exp_q = '{32'd22, 32'd23, 32'd30, 32'd31};
        drain(20);

        // carry-out discarded
        in_valid = 1'b1;
        in_x     = 32'hFFFF_FFFF;
        in_y     = 32'h0000_0002;
        tick();
        in_valid = 1'b0;
        exp_q.push_back(32'h0000_0001);
        drain(10);

        // WIDTH=8, LATENCY=1, FIFO_DEPTH=2
        b_in_valid = 1'b1;
        b_in_x     = 8'hFF;
        b_in_y     = 8'h02;
        tick();
        check("b_e0_ovalid", 32'(b_out_valid), 32'd0);
        b_in_x = 8'h80;
        b_in_y = 8'h80;
        tick();
        check("b_e1_ovalid", 32'(b_out_valid), 32'd1);
        check("b_e1_sum", 32'(b_out_sum), 32'h01);
        check("b_e1_iready", 32'(b_in_ready), 32'd0);
        b_in_x = 8'h11;
        tick();
        check("b_hold_sum", 32'(b_out_sum), 32'h01);
        check("b_hold_iready", 32'(b_in_ready), 32'd0);
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        tick();
        check("b_pop1_ovalid", 32'(b_out_valid), 32'd1);
        check("b_pop1_sum", 32'(b_out_sum), 32'h00);
        tick();
        b_out_ready = 1'b0;
        check("b_pop2_ovalid", 32'(b_out_valid), 32'd0);

        // reset with 2 buffered and 2 in flight
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_x     = 32'(40 + i);
            in_y     = 32'd0;
            tick();
        end
        in_valid = 1'b0;
        check("mrst_pre_ovalid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_ovalid", 32'(out_valid), 32'd0);
        check("mrst_iready", 32'(in_ready), 32'd1);
        check("mrst_sum", out_sum, 32'd0);
        #10;
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_x     = 32'd7;
        in_y     = 32'd9;
        tick();
        in_valid = 1'b0;
        check("mrst_a0_ovalid", 32'(out_valid), 32'd0);
        tick();
        check("mrst_a1_ovalid", 32'(out_valid), 32'd0);
        exp_q.push_back(32'd16);
        drain(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
